// File: rtl/ssd_scan_decoder_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment
// patterns (a..g, bit 6 = a), the idle anode value and the frame FSM encoding.
package ssd_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_IDLE   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } frame_state_t;

endpackage

// File: rtl/ssd_scan_decoder_pattern_decode.sv
// Combinational decode of one active-low segment pattern into a digit value.
// Build option: SSD_DECODE_HEX_EN makes the A-F patterns legal (values 10-15);
// without it they are reported as undecodable.
module ssd_pattern_decode
  import ssd_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       minus,
  output logic       blank,
  output logic       err
);

  // Pattern table lookup; anything not listed is an error with value 0.
  always_comb begin
    value = 4'd0;
    minus = 1'b0;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
`ifdef SSD_DECODE_HEX_EN
      SEG_A:     value = 4'd10;
      SEG_B:     value = 4'd11;
      SEG_C:     value = 4'd12;
      SEG_D:     value = 4'd13;
      SEG_E:     value = 4'd14;
      SEG_F:     value = 4'd15;
`endif
      SEG_MINUS: minus = 1'b1;
      SEG_BLANK: blank = 1'b1;
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Receive side of a multiplexed seven-segment display: synchronizes the
// anode/segment lines, waits for each dwell to be stable, decodes the lit
// digit and publishes complete four-digit frames.
// Build option: SSD_DECODE_HEX_EN (see ssd_pattern_decode).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no digit of the current frame seen yet
// ST_COLLECT | at least one digit captured, waiting for the rest
// ST_PUBLISH | all four digits seen; outputs load on the next edge
module ssd_scan_decoder
  import ssd_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [3:0]  an_in,
  input  logic [6:0]  ssd_in,
  output logic [15:0] digits,
  output logic [3:0]  minus,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        an_err
);

  localparam logic [7:0]  CAP_CNT = 8'(STABLE_CYCLES - 1);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT_CYCLES);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  logic [3:0]   an_m, an_s;
  logic [6:0]   ssd_m, ssd_s;
  logic [10:0]  smp_q;
  logic [7:0]   stab_cnt;
  logic [31:0]  idle_cnt;
  logic [3:0]   seen;
  logic [15:0]  sh_val;
  logic [3:0]   sh_minus, sh_blank, sh_err;
  frame_state_t state, state_next;

  logic         capture, an_legal, an_idle, legal_cap, illegal_cap;
  logic         timeout_eff, frame_done;
  logic [1:0]   slot;
  logic [3:0]   slot_oh, seen_set;
  logic [3:0]   dec_val;
  logic         dec_minus, dec_blank, dec_err;

  // Two-flop synchronizer; reset to the inactive (all-high) line state so the
  // reset value itself never looks like an illegal anode pattern.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      an_m  <= AN_IDLE;
      an_s  <= AN_IDLE;
      ssd_m <= SEG_BLANK;
      ssd_s <= SEG_BLANK;
    end else begin
      an_m  <= an_in;
      an_s  <= an_m;
      ssd_m <= ssd_in;
      ssd_s <= ssd_m;
    end
  end

  // Stability counter: stab_cnt == n means smp_q has held for n+1 cycles.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_q    <= {AN_IDLE, SEG_BLANK};
      stab_cnt <= 8'd0;
    end else begin
      smp_q <= {an_s, ssd_s};
      if ({an_s, ssd_s} != smp_q)
        stab_cnt <= 8'd0;
      else if (stab_cnt != 8'hFF)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // Capture qualification and anode slot selection.
  always_comb begin
    capture     = (stab_cnt == CAP_CNT);
    an_legal    = $onehot(~smp_q[10:7]);
    an_idle     = (smp_q[10:7] == AN_IDLE);
    legal_cap   = capture && an_legal;
    illegal_cap = capture && !an_legal && !an_idle;
    slot_oh     = ~smp_q[10:7];
    slot        = 2'd0;
    for (int k = 0; k < 4; k++)
      if (slot_oh[k]) slot = 2'(k);
    seen_set    = seen | (legal_cap ? slot_oh : 4'b0000);
    frame_done  = legal_cap && (seen_set == 4'b1111);
    // A capture in the expiry cycle restarts the idle period instead.
    timeout_eff = TO_EN && (idle_cnt == TO_LIM) && !legal_cap;
  end

  ssd_pattern_decode u_decode (
    .seg   (smp_q[6:0]),
    .value (dec_val),
    .minus (dec_minus),
    .blank (dec_blank),
    .err   (dec_err)
  );

  // Idle timer since the last legal capture, saturating at the limit.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)
      idle_cnt <= 32'd0;
    else if (legal_cap)
      idle_cnt <= 32'd0;
    else if (idle_cnt != TO_LIM)
      idle_cnt <= idle_cnt + 32'd1;
  end

  // Frame FSM state register.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (legal_cap) state_next = ST_COLLECT;
      ST_COLLECT: if (frame_done)       state_next = ST_PUBLISH;
                  else if (timeout_eff) state_next = ST_IDLE;
      ST_PUBLISH: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Shadow slots and seen mask for the frame under assembly.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      seen     <= 4'd0;
      sh_val   <= 16'd0;
      sh_minus <= 4'd0;
      sh_blank <= 4'd0;
      sh_err   <= 4'd0;
    end else begin
      if (legal_cap) begin
        sh_val[{slot, 2'b00} +: 4] <= dec_val;
        sh_minus[slot]             <= dec_minus;
        sh_blank[slot]             <= dec_blank;
        sh_err[slot]               <= dec_err;
      end
      if (state == ST_PUBLISH || timeout_eff)
        seen <= 4'd0;
      else
        seen <= seen_set;
    end
  end

  // Published frame outputs and one-cycle status pulses.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      digits      <= 16'd0;
      minus       <= 4'd0;
      blank       <= 4'd0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      an_err      <= illegal_cap;
      frame_valid <= (state == ST_PUBLISH);
      if (state == ST_PUBLISH) begin
        digits    <= sh_val;
        minus     <= sh_minus;
        blank     <= sh_blank;
        frame_err <= |sh_err;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Scoreboard bench for ssd_scan_decoder: each scanned frame pushes its expected
// result, and every frame_valid pulse pops and compares one entry.
module tb_ssd_scan_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 100;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  an_in = 4'hF;
  logic [6:0]  ssd_in = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  minus, blank;
  logic        frame_valid, frame_err, an_err;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  m;
    logic [3:0]  b;
    logic        e;
  } frame_t;

  frame_t      exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          frames_seen = 0;
  int          an_err_seen = 0;
  int          an_err_exp = 0;
  logic [6:0]  seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

  ssd_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .an_in       (an_in),
    .ssd_in      (ssd_in),
    .digits      (digits),
    .minus       (minus),
    .blank       (blank),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .an_err      (an_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [6:0] p, output logic [3:0] v,
                                output logic m, output logic b, output logic e);
    v = 4'd0; m = 1'b0; b = 1'b0; e = 1'b0;
    case (p)
      7'b0000001: v = 4'd0;
      7'b1001111: v = 4'd1;
      7'b0010010: v = 4'd2;
      7'b0000110: v = 4'd3;
      7'b1001100: v = 4'd4;
      7'b0100100: v = 4'd5;
      7'b0100000: v = 4'd6;
      7'b0001111: v = 4'd7;
      7'b0000000: v = 4'd8;
      7'b0000100: v = 4'd9;
`ifdef SSD_DECODE_HEX_EN
      7'b0001000: v = 4'hA;
      7'b1100000: v = 4'hB;
      7'b0110001: v = 4'hC;
      7'b1000010: v = 4'hD;
      7'b0110000: v = 4'hE;
      7'b0111000: v = 4'hF;
`endif
      7'b1111110: m = 1'b1;
      7'b1111111: b = 1'b1;
      default:    e = 1'b1;
    endcase
  endfunction

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in  = a;
    ssd_in = s;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                      input logic [6:0] p3, input bit glitch, input bit bad_an);
    logic [6:0] p [4];
    frame_t     f;
    logic [3:0] v, an;
    logic       m, b, e;
    int         t;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      model(p[k], v, m, b, e);
      f.d[4*k +: 4] = v;
      f.m[k] = m;
      f.b[k] = b;
      f.e = f.e | e;
    end
    exp_q.push_back(f);
    for (int k = 0; k < 4; k++) begin
      if (glitch) hold(4'($urandom), 7'($urandom), 2);
      if (bad_an && k == 2) begin
        hold(4'b1010, p[k], 20);
        an_err_exp++;
      end
      an = 4'b0001 << k;
      hold(~an, p[k], 20);
    end
    hold(4'hF, 7'h7F, 20);
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge Clk);
      t++;
    end
    #1;
    chk("frame_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard consumer and pulse counters, sampled away from the active edge.
  always @(negedge Clk) begin
    frame_t e;
    if (reset_n && frame_valid) begin
      frames_seen++;
      chk("frame_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("digits",    32'(digits),    32'(e.d));
        chk("minus",     32'(minus),     32'(e.m));
        chk("blank",     32'(blank),     32'(e.b));
        chk("frame_err", 32'(frame_err), 32'(e.e));
      end
    end
    if (reset_n && an_err) an_err_seen++;
  end

  initial begin
    int fs0;
    logic [6:0] r [4];
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_digits",      32'(digits),      32'd0);
    chk("rst_minus",       32'(minus),       32'd0);
    chk("rst_blank",       32'(blank),       32'd0);
    chk("rst_frame_err",   32'(frame_err),   32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_an_err",      32'(an_err),      32'd0);
    reset_n = 1'b1;
    hold(4'hF, 7'h7F, 10);

    scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 1'b0, 1'b0);
    scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 1'b1, 1'b0);
    chk("glitch_no_an_err", 32'(an_err_seen), 32'(an_err_exp));
    scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 1'b0, 1'b1);
    chk("an_err_count", 32'(an_err_seen), 32'(an_err_exp));

    scan(seg_tab[7], seg_tab[5], 7'b1111110, 7'b1111111, 1'b0, 1'b0);
    scan(7'b1010101, seg_tab[5], 7'b1111110, 7'b1111111, 1'b0, 1'b0);
    scan(7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) r[k] = seg_tab[$urandom_range(9, 0)];
      scan(r[0], r[1], r[2], r[3], 1'b1, 1'b0);
    end

    // Partial frame, timeout, then the missing digit alone: must not publish.
    fs0 = frames_seen;
    hold(4'b1110, seg_tab[6], 20);
    hold(4'b1101, seg_tab[7], 20);
    hold(4'b1011, seg_tab[8], 20);
    hold(4'hF, 7'h7F, TMO + 50);
    hold(4'b0111, seg_tab[9], 20);
    hold(4'hF, 7'h7F, 30);
    chk("timeout_no_frame", 32'(frames_seen), 32'(fs0));

    reset_n = 1'b0;
    hold(4'hF, 7'h7F, 3);
    reset_n = 1'b1;
    hold(4'hF, 7'h7F, 10);
    chk("end_digits",      32'(digits),      32'd0);
    chk("end_minus",       32'(minus),       32'd0);
    chk("end_blank",       32'(blank),       32'd0);
    chk("end_frame_err",   32'(frame_err),   32'd0);
    chk("end_frame_valid", 32'(frame_valid), 32'd0);
    chk("end_frames_seen", 32'(frames_seen), 32'(fs0));
    chk("end_an_err_count", 32'(an_err_seen), 32'(an_err_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
